// File: rtl/sram_serial_top.sv
// Serial-loaded word memory: bits shift in, get latched as write data, and are written/read by address.
// Optional macro SRAM_RD_FORWARD_EN: same-edge write+read performs both, forwarding write data to the read.
module sram_serial_top #(
  parameter int ROWS = 16,
  parameter int COLS = 8,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            serial_in,
  input  logic            shift,
  input  logic            load,
  input  logic            w_en,
  input  logic            r_en,
  input  logic [AW-1:0]   addr,
  output logic            data_valid,
  output logic [COLS-1:0] data_out
);

  logic [COLS-1:0] shift_reg;
  logic [COLS-1:0] wdata_reg;
  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] rd_word;
  logic [COLS-1:0] rd_data;
  logic            rd_accept;

  // Address decode by comparison: out-of-range addresses match no word and read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (addr == AW'(i)) rd_word = mem[i];
    end
  end

`ifdef SRAM_RD_FORWARD_EN
  localparam logic [AW:0] ROWS_W = (AW+1)'(ROWS);
  logic addr_ok;
  assign addr_ok   = ({1'b0, addr} < ROWS_W);
  assign rd_accept = r_en;
  assign rd_data   = (w_en && addr_ok) ? wdata_reg : rd_word;
`else
  assign rd_accept = r_en & ~w_en;
  assign rd_data   = rd_word;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shift_reg <= '0;
      wdata_reg <= '0;
    end else begin
      if (shift) shift_reg <= {shift_reg[COLS-2:0], serial_in};
      if (load)  wdata_reg <= shift_reg;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (w_en && addr == AW'(i)) mem[i] <= wdata_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      data_valid <= rd_accept;
      if (rd_accept) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_sram_serial_top.sv
// Bench for sram_serial_top: vector table, directed corner sequences, and random traffic vs a model.
module tb_sram_serial_top;
  localparam int ROWS = 12;
  localparam int COLS = 8;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic            serial_in = 1'b0;
  logic            shift = 1'b0;
  logic            load = 1'b0;
  logic            w_en = 1'b0;
  logic            r_en = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic            data_valid;
  logic [COLS-1:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [COLS-1:0] m_mem [ROWS];
  logic [COLS-1:0] m_shift, m_wdata, m_dout;
  logic            m_dv;

`ifdef SRAM_RD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  sram_serial_top #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .arst_n(arst_n), .serial_in(serial_in), .shift(shift), .load(load),
    .w_en(w_en), .r_en(r_en), .addr(addr), .data_valid(data_valid), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sh, si, ld, we, re;
    int   a;
    logic [COLS-1:0] exp_do;
    logic exp_dv;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ROWS; i++) m_mem[i] = '0;
    m_shift = '0; m_wdata = '0; m_dout = '0; m_dv = 1'b0;
  endtask

  // One clock: apply inputs, advance the model by the functional rules, compare after the edge.
  task automatic drive(input logic sh, input logic si, input logic ld, input logic we,
                       input logic re, input int a);
    logic [COLS-1:0] n_shift, n_wdata, n_dout;
    logic            accept;
    bit              in_rng;
    @(negedge clk);
    shift = sh; serial_in = si; load = ld; w_en = we; r_en = re; addr = AW'(a);
    in_rng  = (a < ROWS);
    n_shift = sh ? {m_shift[COLS-2:0], si} : m_shift;
    n_wdata = ld ? m_shift : m_wdata;
    accept  = re && (!we || FWD);
    n_dout  = m_dout;
    if (accept) n_dout = !in_rng ? '0 : (we ? m_wdata : m_mem[a]);
    @(posedge clk);
    #1;
    if (we && in_rng) m_mem[a] = m_wdata;
    m_shift = n_shift; m_wdata = n_wdata; m_dout = n_dout; m_dv = accept;
    chk("model_data_out", 32'(data_out), 32'(m_dout));
    chk("model_data_valid", 32'(data_valid), 32'(m_dv));
    $display("cyc sh=%0b si=%0b ld=%0b we=%0b re=%0b a=%0d -> do=%h dv=%0b",
             sh, si, ld, we, re, a, data_out, data_valid);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_word(input logic [COLS-1:0] w);
    for (int b = COLS - 1; b >= 0; b--) drive(1, w[b], 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    shift = 0; load = 0; w_en = 0; r_en = 0;
    arst_n = 1'b0;
    model_clear();
    #20;
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
  endtask

  initial begin
    model_clear();
    #20;
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);

    // Every address (including out-of-range) reads zero after reset.
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 0, 1, a);
      chk("rst_read_zero", 32'(data_out), 32'h0);
      chk("rst_read_valid", 32'(data_valid), 32'h1);
    end

    // Serial load of 1010_0101 into addr 3, then read back.
    for (int b = 0; b < 8; b++)
      vecs.push_back('{1'b1, 1'(8'hA5 >> (7 - b)), 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'hA5, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hA5, 1'b0});
    foreach (vecs[i]) begin
      drive(vecs[i].sh, vecs[i].si, vecs[i].ld, vecs[i].we, vecs[i].re, vecs[i].a);
      chk($sformatf("table[%0d]_data_out", i), 32'(data_out), 32'(vecs[i].exp_do));
      chk($sformatf("table[%0d]_data_valid", i), 32'(data_valid), 32'(vecs[i].exp_dv));
    end

    // Write each row with its index, then read all rows.
    for (int r = 0; r < ROWS; r++) begin
      load_word(COLS'(r));
      drive(0, 0, 0, 1, 0, r);
    end
    for (int r = 0; r < ROWS; r++) begin
      drive(0, 0, 0, 0, 1, r);
      chk("row_read", 32'(data_out), 32'(r));
    end
    idle();
    chk("row_read_dv_drop", 32'(data_valid), 32'h0);

    // Back-to-back reads keep data_valid high with fresh data.
    drive(0, 0, 0, 0, 1, 1);
    chk("b2b_first", 32'(data_out), 32'h1);
    chk("b2b_first_dv", 32'(data_valid), 32'h1);
    drive(0, 0, 0, 0, 1, 2);
    chk("b2b_second", 32'(data_out), 32'h2);
    chk("b2b_second_dv", 32'(data_valid), 32'h1);
    idle();
    chk("b2b_hold", 32'(data_out), 32'h2);
    chk("b2b_dv_low", 32'(data_valid), 32'h0);

    // Simultaneous write and read at addr 5 with write data 3C.
    load_word(8'h3C);
    drive(0, 0, 0, 1, 1, 5);
`ifdef SRAM_RD_FORWARD_EN
    chk("wr_rd_fwd_data", 32'(data_out), 32'h3C);
    chk("wr_rd_fwd_dv", 32'(data_valid), 32'h1);
`else
    chk("wr_rd_drop_dv", 32'(data_valid), 32'h0);
    chk("wr_rd_drop_hold", 32'(data_out), 32'h2);
`endif
    drive(0, 0, 0, 0, 1, 5);
    chk("wr_rd_later", 32'(data_out), 32'h3C);

    // Load and write on the same edge store the old write data.
    load_word(8'h5A);
    for (int b = 7; b >= 0; b--) drive(1, 1'(8'hC3 >> b), 0, 0, 0, 0);
    drive(1, 1, 1, 1, 0, 7);
    drive(0, 0, 0, 0, 1, 7);
    chk("ld_wr_same_edge", 32'(data_out), 32'h5A);

    // Out-of-range write ignored, read returns zero with valid.
    drive(0, 0, 0, 1, 0, 13);
    drive(0, 0, 0, 0, 1, 13);
    chk("oor_read_zero", 32'(data_out), 32'h0);
    chk("oor_read_dv", 32'(data_valid), 32'h1);

    // Reset asserted during a read cycle, before the edge.
    @(negedge clk);
    r_en = 1'b1; addr = 4'd3;
    #2;
    arst_n = 1'b0;
    #1;
    chk("async_clear_dout", 32'(data_out), 32'h0);
    chk("async_clear_dv", 32'(data_valid), 32'h0);
    r_en = 1'b0;
    model_clear();
    #20;
    @(negedge clk);
    arst_n = 1'b1;
    idle();
    chk("midrd_dv_low", 32'(data_valid), 32'h0);
    drive(0, 0, 0, 0, 1, 3);
    chk("midrd_mem_zero", 32'(data_out), 32'h0);
    chk("midrd_read_dv", 32'(data_valid), 32'h1);

    // Random traffic against the model, with one reset in the middle.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_serial_top.md
SRAM_SERIAL_TOP -- requirements
Module: sram_serial_top

Interface
REQ-001 The block SHALL have parameter ROWS, default 16, number of memory words.
REQ-002 The block SHALL have parameter COLS, default 8, bits per word (COLS >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port arst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port serial_in, input, 1 bit, serial write-data bit.
REQ-006 The block SHALL have port shift, input, 1 bit, shifts serial_in into the shift register.
REQ-007 The block SHALL have port load, input, 1 bit, copies the shift register into the write-data register.
REQ-008 The block SHALL have port w_en, input, 1 bit, write strobe.
REQ-009 The block SHALL have port r_en, input, 1 bit, read strobe.
REQ-010 The block SHALL have port addr, input, $clog2(ROWS) bits, word address for read and write.
REQ-011 The block SHALL have port data_valid, output, 1 bit, one-cycle read-data-valid pulse.
REQ-012 The block SHALL have port data_out, output, COLS bits, registered read data.

Function
REQ-013 On each edge with shift=1, shift_reg SHALL become {shift_reg[COLS-2:0], serial_in}, so the first bit shifted in is the MSB after COLS shifts.
REQ-014 On each edge with load=1, wdata_reg SHALL take the pre-edge shift_reg value, including when shift=1 on the same edge.
REQ-015 On each edge with w_en=1 and addr < ROWS, mem[addr] SHALL take the pre-edge wdata_reg value; when load=1 on the same edge, the old wdata_reg is written.
REQ-016 On each edge with r_en=1 and w_en=0, data_out SHALL take mem[addr] and data_valid SHALL be 1 for exactly that following cycle (1-cycle latency).
REQ-017 data_valid SHALL be 0 in every cycle not directly following an accepted read.
REQ-018 data_out SHALL hold its last read value until the next accepted read.
REQ-019 Back-to-back reads SHALL each produce one valid cycle with new data; data_valid then stays high continuously.
REQ-020 Writes with addr >= ROWS SHALL be ignored; reads with addr >= ROWS SHALL return all zeros with data_valid=1.
REQ-021 When w_en and r_en are both 1 on the same edge, the behaviour SHALL follow the rules in Configuration.
REQ-022 shift, load, w_en and r_en SHALL be independent; any combination on one edge is legal.

Reset
REQ-023 While arst_n=0, and immediately on its assertion regardless of clk, the block SHALL clear shift_reg, wdata_reg, data_out, data_valid and every mem word to 0.
REQ-024 Reset asserted mid-operation SHALL abort any pending read, so data_valid is 0 in the cycle after reset is released.
REQ-025 The first edge after arst_n rises SHALL be fully functional.

Configuration
REQ-026 Macro SRAM_RD_FORWARD_EN SHALL control simultaneous w_en and r_en on the same edge.
REQ-027 With SRAM_RD_FORWARD_EN defined, both operations SHALL occur: data_out SHALL be the pre-edge wdata_reg when the addresses match, else mem[addr], with data_valid=1.
REQ-028 Without SRAM_RD_FORWARD_EN, the write SHALL take priority, the read SHALL be dropped, and data_valid SHALL stay 0.

Verification
REQ-029 Reset check: reset for 20 ns and release -> data_out=0, data_valid=0; reading any address returns 0.
REQ-030 Serial load: shift 1,0,1,0,0,1,0,1 (COLS=8), then load, then w_en at addr 3 -> a later read of addr 3 gives data_out=8'hA5 and data_valid=1 for one cycle, 1 cycle after r_en.
REQ-031 Full write/read: write each row r with value r (shift, load, write), then read rows 0..ROWS-1 -> each data_out equals its row index.
REQ-032 Back-to-back reads of addr 1 and 2 -> data_valid high 2 cycles, data_out 1 then 2.
REQ-033 Simultaneous w_en+r_en at addr 5 with wdata 8'h3C -> with the macro, data_out=8'h3C and data_valid=1; without it, data_valid=0 and a later read gives 8'h3C.
REQ-034 Reset mid-read: assert arst_n=0 in the r_en cycle -> data_valid stays 0 and memory reads back 0.
